// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store writeback block: FSM states,
// default widths and the word-alignment mask.
package lsu_pkg;

    localparam int DATA_W_DEF      = 32;
    localparam int ADDR_W_DEF      = 32;
    localparam int REG_AW_DEF      = 5;
    localparam int TIMEOUT_CYC_DEF = 255;

    // Low address bits that must be zero for a word access.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        WB   = 2'd2
    } state_e;

    function automatic logic word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/lsu_writeback_if.sv
// Issue, data-memory and register-file-write signals of lsu_writeback.
// master: the writeback block itself. slave: its environment
// (issue stage, data memory, register file).
interface lsu_writeback_if
    import lsu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) ();

    logic              iss_valid;
    logic              iss_ready;
    logic              iss_load;
    logic              iss_store;
    logic [DATA_W-1:0] iss_base;
    logic [DATA_W-1:0] iss_wdata;
    logic [DATA_W-1:0] iss_offset;
    logic [DATA_W-1:0] iss_alu;
    logic [REG_AW-1:0] iss_dest;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    logic              rf_we;
    logic [REG_AW-1:0] rf_dest;
    logic [DATA_W-1:0] rf_alu_data;
    logic [DATA_W-1:0] rf_mem_data;
    logic              rf_mem_sel;

    modport master (
        input  iss_valid, iss_load, iss_store, iss_base, iss_wdata,
               iss_offset, iss_alu, iss_dest,
        output iss_ready,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata,
        output rf_we, rf_dest, rf_alu_data, rf_mem_data, rf_mem_sel
    );

    modport slave (
        output iss_valid, iss_load, iss_store, iss_base, iss_wdata,
               iss_offset, iss_alu, iss_dest,
        input  iss_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata,
        input  rf_we, rf_dest, rf_alu_data, rf_mem_data, rf_mem_sel
    );

endinterface

// File: rtl/lsu_timeout_ctr.sv
// Loadable down-counter for the memory-ack watchdog. Loaded with
// (limit - 1) on entry to the wait state; expire_o is high during the
// last allowed cycle while run_i is set.
module lsu_timeout_ctr #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             run_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] cnt_q;

    // Count down while running; a load restarts the window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (run_i && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expire_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/lsu_writeback.sv
// Register-file write-port owner: ALU results go straight to writeback,
// word loads/stores run one transaction on the data-memory bus first.
// Optional build macro LSU_TIMEOUT_EN adds a watchdog on mem_ack.
module lsu_writeback
    import lsu_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int REG_AW      = REG_AW_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    lsu_writeback_if.master bus,
    output logic            err
);

    state_e            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              rf_we_q, rf_we_d;
    logic [REG_AW-1:0] rf_dest_q, rf_dest_d;
    logic [DATA_W-1:0] rf_alu_data_q, rf_alu_data_d;
    logic [DATA_W-1:0] rf_mem_data_q, rf_mem_data_d;
    logic              rf_mem_sel_q, rf_mem_sel_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] ea_full;
    logic [ADDR_W-1:0] ea;
    logic              is_mem_op;
    logic              tmo_load;
    logic              tmo_expire;

    assign ea_full   = bus.iss_base + bus.iss_offset;
    assign ea        = ea_full[ADDR_W-1:0];
    assign is_mem_op = bus.iss_load | bus.iss_store;

`ifdef LSU_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT_CYC - 1);

    lsu_timeout_ctr #(
        .CNT_W (CNT_W)
    ) u_timeout_ctr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmo_load),
        .load_val_i (TMO_LOAD),
        .run_i      (state_q == MEM),
        .expire_o   (tmo_expire)
    );
`else
    // Watchdog compiled out: MEM waits for mem_ack indefinitely.
    assign tmo_expire = tmo_load & 1'b0 & (TIMEOUT_CYC != 0);
`endif

    // Next-state and next-output decode; outputs are all registered.
    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        rf_we_d       = 1'b0;
        rf_dest_d     = rf_dest_q;
        rf_alu_data_d = rf_alu_data_q;
        rf_mem_data_d = rf_mem_data_q;
        rf_mem_sel_d  = rf_mem_sel_q;
        err_d         = 1'b0;
        tmo_load      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.iss_valid) begin
                    if (!is_mem_op) begin
                        rf_dest_d     = bus.iss_dest;
                        rf_alu_data_d = bus.iss_alu;
                        rf_mem_sel_d  = 1'b0;
                        rf_we_d       = 1'b1;
                        state_d       = WB;
                    end else if (!word_aligned(ea[1:0])) begin
                        err_d = 1'b1;
                    end else begin
                        // Load wins when both load and store are flagged.
                        mem_req_d   = 1'b1;
                        mem_we_d    = bus.iss_store & ~bus.iss_load;
                        mem_addr_d  = ea;
                        mem_wdata_d = bus.iss_wdata;
                        if (bus.iss_load) begin
                            rf_dest_d = bus.iss_dest;
                        end
                        tmo_load    = 1'b1;
                        state_d     = MEM;
                    end
                end
            end
            MEM: begin
                if (bus.mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (!mem_we_q) begin
                        rf_mem_data_d = bus.mem_rdata;
                        rf_mem_sel_d  = 1'b1;
                        rf_we_d       = 1'b1;
                        state_d       = WB;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (tmo_expire) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    err_d     = 1'b1;
                    state_d   = IDLE;
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            rf_we_q       <= 1'b0;
            rf_dest_q     <= '0;
            rf_alu_data_q <= '0;
            rf_mem_data_q <= '0;
            rf_mem_sel_q  <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            rf_we_q       <= rf_we_d;
            rf_dest_q     <= rf_dest_d;
            rf_alu_data_q <= rf_alu_data_d;
            rf_mem_data_q <= rf_mem_data_d;
            rf_mem_sel_q  <= rf_mem_sel_d;
            err_q         <= err_d;
        end
    end

    assign bus.iss_ready   = (state_q == IDLE);
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.rf_we       = rf_we_q;
    assign bus.rf_dest     = rf_dest_q;
    assign bus.rf_alu_data = rf_alu_data_q;
    assign bus.rf_mem_data = rf_mem_data_q;
    assign bus.rf_mem_sel  = rf_mem_sel_q;
    assign err             = err_q;

endmodule

// File: tb/tb_lsu_writeback.sv
// Self-checking bench for lsu_writeback: directed plan items followed by
// randomized ALU/load/store traffic against a word-addressed memory model.
module tb_lsu_writeback;

`ifdef LSU_TIMEOUT_EN
    localparam int TMO     = 4;
`else
    localparam int TMO     = 255;
`endif
    localparam int MAX_LAT = 4;

    logic clk = 1'b0;
    logic rst;
    logic err;

    lsu_writeback_if bus ();

    lsu_writeback #(
        .DATA_W      (32),
        .ADDR_W      (32),
        .REG_AW      (5),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .err (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference memory: words written by stores; unwritten words read back
    // as a fixed scramble of their address.
    logic [31:0] mem_model [logic [31:0]];

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 32'hA5A5_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.iss_valid  = 1'b0;
        bus.iss_load   = 1'b0;
        bus.iss_store  = 1'b0;
        bus.iss_base   = '0;
        bus.iss_wdata  = '0;
        bus.iss_offset = '0;
        bus.iss_alu    = '0;
        bus.iss_dest   = '0;
        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = '0;
    endtask

    task automatic check_cleared(input string pfx);
        check({pfx, "_iss_ready"},   {31'b0, bus.iss_ready}, 32'd1);
        check({pfx, "_mem_req"},     {31'b0, bus.mem_req},   32'd0);
        check({pfx, "_mem_we"},      {31'b0, bus.mem_we},    32'd0);
        check({pfx, "_rf_we"},       {31'b0, bus.rf_we},     32'd0);
        check({pfx, "_rf_mem_sel"},  {31'b0, bus.rf_mem_sel},32'd0);
        check({pfx, "_err"},         {31'b0, err},           32'd0);
        check({pfx, "_mem_addr"},    bus.mem_addr,           32'd0);
        check({pfx, "_mem_wdata"},   bus.mem_wdata,          32'd0);
        check({pfx, "_rf_dest"},     {27'b0, bus.rf_dest},   32'd0);
        check({pfx, "_rf_alu_data"}, bus.rf_alu_data,        32'd0);
        check({pfx, "_rf_mem_data"}, bus.rf_mem_data,        32'd0);
    endtask

    // ALU op: written back the cycle after acceptance, ready low one cycle.
    task automatic run_alu(input logic [4:0] dest, input logic [31:0] alu);
        check("alu_ready_pre", {31'b0, bus.iss_ready}, 32'd1);
        bus.iss_valid = 1'b1;
        bus.iss_alu   = alu;
        bus.iss_dest  = dest;
        @(negedge clk);
        bus.iss_valid = 1'b0;
        check("alu_rf_we",       {31'b0, bus.rf_we},      32'd1);
        check("alu_rf_dest",     {27'b0, bus.rf_dest},    {27'b0, dest});
        check("alu_rf_mem_sel",  {31'b0, bus.rf_mem_sel}, 32'd0);
        check("alu_rf_alu_data", bus.rf_alu_data,         alu);
        check("alu_ready_busy",  {31'b0, bus.iss_ready},  32'd0);
        check("alu_mem_req",     {31'b0, bus.mem_req},    32'd0);
        @(negedge clk);
        check("alu_rf_we_off",   {31'b0, bus.rf_we},      32'd0);
        check("alu_ready_back",  {31'b0, bus.iss_ready},  32'd1);
        $display("ALU   dest=%0d data=%08h", dest, alu);
    endtask

    // Load/store: misaligned aborts with err; otherwise the request is held
    // for lat cycles, ack arrives on the last one.
    task automatic run_mem(input bit ld, input bit st, input logic [31:0] base,
                           input logic [31:0] off, input logic [31:0] wdata,
                           input logic [4:0] dest, input int lat);
        logic [31:0] ea;
        logic [31:0] exp_rd;
        bit          as_load;
        ea      = base + off;
        as_load = ld;
        check("mem_ready_pre", {31'b0, bus.iss_ready}, 32'd1);
        bus.iss_valid  = 1'b1;
        bus.iss_load   = ld;
        bus.iss_store  = st;
        bus.iss_base   = base;
        bus.iss_offset = off;
        bus.iss_wdata  = wdata;
        bus.iss_dest   = dest;
        @(negedge clk);
        bus.iss_valid = 1'b0;
        bus.iss_load  = 1'b0;
        bus.iss_store = 1'b0;
        if (ea[1:0] != 2'b00) begin
            check("mis_err",     {31'b0, err},           32'd1);
            check("mis_mem_req", {31'b0, bus.mem_req},   32'd0);
            check("mis_rf_we",   {31'b0, bus.rf_we},     32'd0);
            check("mis_ready",   {31'b0, bus.iss_ready}, 32'd1);
            @(negedge clk);
            check("mis_err_off", {31'b0, err},           32'd0);
            check("mis_mem_req2",{31'b0, bus.mem_req},   32'd0);
            check("mis_rf_we2",  {31'b0, bus.rf_we},     32'd0);
            $display("%s misaligned addr=%08h err", as_load ? "LOAD " : "STORE", ea);
            return;
        end
        check("mem_err", {31'b0, err}, 32'd0);
        for (int i = 0; i < lat; i++) begin
            check("mem_req_held", {31'b0, bus.mem_req},   32'd1);
            check("mem_we",       {31'b0, bus.mem_we},    {31'b0, !as_load});
            check("mem_addr",     bus.mem_addr,           ea);
            if (!as_load) check("mem_wdata", bus.mem_wdata, wdata);
            check("mem_ready",    {31'b0, bus.iss_ready}, 32'd0);
            check("mem_rf_we",    {31'b0, bus.rf_we},     32'd0);
            if (i == lat - 1) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = as_load ? mem_read(ea) : $urandom;
            end
            @(negedge clk);
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = $urandom;
        end
        if (as_load) begin
            exp_rd = mem_read(ea);
            check("ld_rf_we",       {31'b0, bus.rf_we},      32'd1);
            check("ld_rf_dest",     {27'b0, bus.rf_dest},    {27'b0, dest});
            check("ld_rf_mem_sel",  {31'b0, bus.rf_mem_sel}, 32'd1);
            check("ld_rf_mem_data", bus.rf_mem_data,         exp_rd);
            check("ld_mem_req_off", {31'b0, bus.mem_req},    32'd0);
            check("ld_ready_wb",    {31'b0, bus.iss_ready},  32'd0);
            @(negedge clk);
            check("ld_rf_we_off",   {31'b0, bus.rf_we},      32'd0);
            check("ld_ready_back",  {31'b0, bus.iss_ready},  32'd1);
            $display("LOAD  addr=%08h lat=%0d dest=%0d data=%08h", ea, lat, dest, exp_rd);
        end else begin
            mem_model[ea] = wdata;
            check("st_ready_back",  {31'b0, bus.iss_ready},  32'd1);
            check("st_mem_req_off", {31'b0, bus.mem_req},    32'd0);
            check("st_rf_we",       {31'b0, bus.rf_we},      32'd0);
            $display("STORE addr=%08h lat=%0d data=%08h", ea, lat, wdata);
        end
    endtask

    // An ack while idle must have no effect.
    task automatic stray_ack();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = $urandom;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check("stray_rf_we",   {31'b0, bus.rf_we},     32'd0);
        check("stray_mem_req", {31'b0, bus.mem_req},   32'd0);
        check("stray_ready",   {31'b0, bus.iss_ready}, 32'd1);
        check("stray_err",     {31'b0, err},           32'd0);
        $display("ACK   stray ack while idle");
    endtask

    initial begin
        logic [31:0] base;
        logic [31:0] off;
        int          op;
        idle_inputs();

        // Reset state
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_cleared("rst");
        rst = 1'b0;
        @(negedge clk);

        // Directed plan items
        run_alu(5'd7, 32'hDEAD_BEEF);
        mem_model[32'h0000_00FC] = 32'h1234_5678;
        run_mem(1'b1, 1'b0, 32'h0000_0100, 32'hFFFF_FFFC, 32'h0, 5'd3, 4);
        run_mem(1'b0, 1'b1, 32'h0000_0200, 32'h0000_0008, 32'hCAFE_F00D, 5'd0, 2);
        run_mem(1'b1, 1'b0, 32'h0000_0101, 32'h0000_0000, 32'h0, 5'd9, 1);
        run_alu(5'd0, 32'h0000_0055);
        run_mem(1'b1, 1'b0, 32'h0000_0200, 32'h0000_0008, 32'h0, 5'd0, 1);
        run_mem(1'b1, 1'b1, 32'h0000_0200, 32'h0000_0008, 32'h1111_2222, 5'd31, 3);
        stray_ack();

        // Reset in the middle of a memory transaction
        bus.iss_valid  = 1'b1;
        bus.iss_load   = 1'b1;
        bus.iss_base   = 32'h0000_0300;
        bus.iss_offset = 32'h0000_0004;
        bus.iss_dest   = 5'd12;
        @(negedge clk);
        bus.iss_valid = 1'b0;
        bus.iss_load  = 1'b0;
        check("rstmem_req_pre", {31'b0, bus.mem_req}, 32'd1);
        #2 rst = 1'b1;
        #1 check_cleared("rstmem");
        @(negedge clk);
        rst = 1'b0;
        $display("RESET during MEM");
        stray_ack();

`ifdef LSU_TIMEOUT_EN
        // No ack: request dropped after TMO cycles with a single err pulse
        bus.iss_valid  = 1'b1;
        bus.iss_load   = 1'b1;
        bus.iss_base   = 32'h0000_0400;
        bus.iss_offset = 32'h0000_0000;
        bus.iss_dest   = 5'd4;
        @(negedge clk);
        bus.iss_valid = 1'b0;
        bus.iss_load  = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            check("tmo_req_held", {31'b0, bus.mem_req}, 32'd1);
            check("tmo_err_low",  {31'b0, err},         32'd0);
            @(negedge clk);
        end
        check("tmo_req_off", {31'b0, bus.mem_req},   32'd0);
        check("tmo_err",     {31'b0, err},           32'd1);
        check("tmo_rf_we",   {31'b0, bus.rf_we},     32'd0);
        check("tmo_ready",   {31'b0, bus.iss_ready}, 32'd1);
        @(negedge clk);
        check("tmo_err_off", {31'b0, err},           32'd0);
        check("tmo_rf_we2",  {31'b0, bus.rf_we},     32'd0);
        $display("TIMEOUT load abandoned after %0d cycles", TMO);
`endif

        // Randomized traffic over a small address window so loads hit stores
        for (int n = 0; n < 40; n++) begin
            op   = $urandom_range(0, 9);
            base = 32'h0000_1000 + (32'($urandom_range(0, 7)) << 2);
            off  = (32'($urandom_range(0, 3)) << 2);
            if ($urandom_range(0, 5) == 0) off = off + 32'($urandom_range(1, 3));
            if (op <= 2) begin
                run_alu(5'($urandom_range(0, 31)), $urandom);
            end else if (op <= 5) begin
                run_mem(1'b1, ($urandom_range(0, 4) == 0), base, off, $urandom,
                        5'($urandom_range(0, 31)), $urandom_range(1, MAX_LAT));
            end else if (op <= 8) begin
                run_mem(1'b0, 1'b1, base, off, $urandom, 5'($urandom_range(0, 31)),
                        $urandom_range(1, MAX_LAT));
            end else begin
                stray_ack();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_writeback.md
Name: lsu_writeback

Overview:
- Writer side of the 32x32 register file write port. Accepts one decoded instruction per handshake, carrying operands read from the register file.
- ALU-only ops: forwards the result to the register file.
- Loads and stores: runs a single word transaction on the data-memory bus; loads are written back through the memory-select path.
- Sits between operand fetch/ALU and the register file; the only agent that drives its write_enable, dest and data-select inputs.

Parameters:
- DATA_W, 32, data and register width.
- ADDR_W, 32, memory address width.
- REG_AW, 5, register index width (32 registers).
- TIMEOUT_CYC, 255, maximum cycles to wait for mem_ack (only used with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- iss_valid  in  1  instruction offered.
- iss_ready  out  1  block can accept an instruction.
- iss_load  in  1  op is a word load.
- iss_store  in  1  op is a word store.
- iss_base  in  DATA_W  base address (register-file read port 1).
- iss_wdata  in  DATA_W  store data (register-file read port 2).
- iss_offset  in  DATA_W  sign-extended immediate offset.
- iss_alu  in  DATA_W  ALU result for non-memory ops.
- iss_dest  in  REG_AW  destination register.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  DATA_W  store data.
- mem_ack  in  1  transaction complete.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.
- rf_we  out  1  register-file write enable.
- rf_dest  out  REG_AW  register-file write index.
- rf_alu_data  out  DATA_W  register-file ALU data input.
- rf_mem_data  out  DATA_W  register-file memory data input.
- rf_mem_sel  out  1  1 = write rf_mem_data, 0 = write rf_alu_data.
- err  out  1  one-cycle pulse on aborted memory op.

Behaviour:
- Reset (async, rst=1): state IDLE. iss_ready=1. mem_req, mem_we, rf_we, rf_mem_sel and err = 0. mem_addr, mem_wdata, rf_dest, rf_alu_data and rf_mem_data = 0.
- States:
  - IDLE: iss_ready=1. Leaves on iss_valid & iss_ready.
  - MEM: mem_req=1.
  - WB: rf_we=1.
- Acceptance in IDLE:
  - Neither load nor store: capture dest and alu -> WB with rf_mem_sel=0.
  - Load or store: compute addr = iss_base + iss_offset (mod 2^ADDR_W).
  - Address misaligned (addr[1:0] != 0): no request, err=1 next cycle, stay IDLE, no writeback.
  - Address aligned: -> MEM.
  - iss_load and iss_store both set: treated as load.
- MEM: mem_req, mem_we, mem_addr and mem_wdata are registered and held stable until the cycle mem_ack=1.
  - On ack, load: capture mem_rdata into rf_mem_data -> WB with rf_mem_sel=1.
  - On ack, store: -> IDLE; mem_req drops the next cycle.
  - mem_ack outside MEM is ignored.
- WB: rf_we=1 for exactly one cycle, with rf_dest/data/sel stable -> IDLE. rf_we is never asserted in any other state.
- Latency:
  - ALU op accepted at cycle N: rf_we at N+1.
  - Load accepted at N: mem_req from N+1, ack at M >= N+1, rf_we at M+1.
  - Store accepted at N: iss_ready returns at M+1.
- Throughput: one instruction in flight. iss_ready=0 in MEM and WB.
- Register 0 is written like any other register; the register file has no hardwired zero.
- Reset mid-MEM abandons the transaction. The memory side is reset by the same rst.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- With it defined: a counter runs while in MEM. If mem_ack has not arrived after TIMEOUT_CYC cycles in MEM, the block drops mem_req, pulses err for one cycle, skips writeback and returns to IDLE. The counter clears on entry to MEM.
- Without it: MEM waits indefinitely, and err signals misalignment only.

Decomposition:
- Shared package lsu_pkg holds:
  - the state enum (IDLE, MEM, WB);
  - DATA_W, ADDR_W and REG_AW defaults;
  - the alignment mask constant.
- One natural sub-module, lsu_timeout_ctr: loadable down-counter with an expire pulse, instantiated only under LSU_TIMEOUT_EN.

Test Plan:
- ALU op, alu=0xDEADBEEF, dest=7 -> one cycle later rf_we=1, rf_dest=7, rf_mem_sel=0, rf_alu_data=0xDEADBEEF; iss_ready low for exactly one cycle.
- Load base=0x100, offset=0xFFFFFFFC, dest=3; memory acks after 4 cycles with 0x12345678 -> mem_addr=0xFC held for 4 cycles; next cycle rf_we=1, rf_dest=3, rf_mem_sel=1, rf_mem_data=0x12345678.
- Store base=0x200, offset=8, wdata=0xCAFEF00D, ack after 2 cycles -> mem_we=1, mem_addr=0x208, mem_wdata=0xCAFEF00D; no rf_we; iss_ready returns the cycle after ack.
- Load base=0x101 -> err pulses once, no mem_req, no rf_we; the next instruction is accepted immediately.
- rst asserted during MEM -> all outputs go to 0 combinationally and iss_ready=1; a later ack is ignored.
- LSU_TIMEOUT_EN with TIMEOUT_CYC=4, no ack -> mem_req drops after 4 cycles, err pulses once, no rf_we.
